// File: rtl/rr_decode_arbiter.sv
// Round-robin arbiter for one 8-way decoded resource: registered one-hot grant plus binary index.
// Define ARB_GRANT_COUNT_EN to add the saturating grant_count output.
module rr_decode_arbiter #(
  parameter int MAX_HOLD = 4,
  parameter int CNT_W    = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] req,
  output logic [7:0] gnt,
  output logic [2:0] gnt_idx,
  output logic       gnt_valid
`ifdef ARB_GRANT_COUNT_EN
  ,
  output logic [CNT_W-1:0] grant_count
`endif
);

  localparam int HW = (MAX_HOLD < 1) ? 1 : $clog2(MAX_HOLD + 1);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  state_t          state_reg, state_next;
  logic [2:0]      ptr_reg, ptr_next;
  logic [HW-1:0]   hold_cnt_reg, hold_cnt_next;
  logic [7:0]      gnt_reg, gnt_next;
  logic [2:0]      gnt_idx_reg, gnt_idx_next;
  logic            gnt_valid_reg, gnt_valid_next;
  logic            grant_start;
  logic [7:0]      req_rot;
  logic [2:0]      win_off;
  logic [2:0]      win_idx;
  logic            timeout;

  // Rotate requests so bit 0 is the requester at ptr; the 3-bit index sum wraps modulo 8.
  generate
    for (genvar gi = 0; gi < 8; gi++) begin : g_rot
      assign req_rot[gi] = req[3'(gi) + ptr_reg];
    end
  endgenerate

  always_comb begin
    win_off = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (req_rot[i]) win_off = 3'(i);
    end
  end

  assign win_idx = ptr_reg + win_off;
  assign timeout = (MAX_HOLD != 0) && (hold_cnt_reg == HW'(MAX_HOLD));

  always_comb begin
    state_next     = state_reg;
    ptr_next       = ptr_reg;
    hold_cnt_next  = hold_cnt_reg;
    gnt_next       = gnt_reg;
    gnt_idx_next   = gnt_idx_reg;
    gnt_valid_next = gnt_valid_reg;
    grant_start    = 1'b0;
    case (state_reg)
      IDLE: begin
        if (req != 8'd0) begin
          state_next     = GRANT;
          gnt_idx_next   = win_idx;
          gnt_next       = 8'd1 << win_idx;
          gnt_valid_next = 1'b1;
          hold_cnt_next  = HW'(1);
          grant_start    = 1'b1;
        end
      end
      GRANT: begin
        // Release and timeout both end in an idle bubble and advance ptr past the winner.
        if (!req[gnt_idx_reg] || timeout) begin
          state_next     = IDLE;
          gnt_next       = 8'd0;
          gnt_valid_next = 1'b0;
          ptr_next       = gnt_idx_reg + 3'd1;
        end else if (hold_cnt_reg < HW'(MAX_HOLD)) begin
          hold_cnt_next = hold_cnt_reg + HW'(1);
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg     <= IDLE;
      ptr_reg       <= 3'd0;
      hold_cnt_reg  <= '0;
      gnt_reg       <= 8'd0;
      gnt_idx_reg   <= 3'd0;
      gnt_valid_reg <= 1'b0;
    end else begin
      state_reg     <= state_next;
      ptr_reg       <= ptr_next;
      hold_cnt_reg  <= hold_cnt_next;
      gnt_reg       <= gnt_next;
      gnt_idx_reg   <= gnt_idx_next;
      gnt_valid_reg <= gnt_valid_next;
    end
  end

  assign gnt       = gnt_reg;
  assign gnt_idx   = gnt_idx_reg;
  assign gnt_valid = gnt_valid_reg;

`ifdef ARB_GRANT_COUNT_EN
  logic [CNT_W-1:0] grant_count_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      grant_count_reg <= '0;
    end else if (grant_start && (grant_count_reg != {CNT_W{1'b1}})) begin
      grant_count_reg <= grant_count_reg + CNT_W'(1);
    end
  end

  assign grant_count = grant_count_reg;
`else
  logic [CNT_W-1:0] unused_cnt_w;
  logic             unused_start;
  assign unused_cnt_w = '0;
  assign unused_start = grant_start;
`endif

endmodule

// File: tb/tb_rr_decode_arbiter.sv
// Directed bench for rr_decode_arbiter: one instance with MAX_HOLD=4, one with MAX_HOLD=0.
// Inputs change and outputs are sampled 1 time unit after each rising edge.
module tb_rr_decode_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] req_a, req_b;
  logic [7:0] gnt_a, gnt_b;
  logic [2:0] idx_a, idx_b;
  logic       valid_a, valid_b;
`ifdef ARB_GRANT_COUNT_EN
  logic [15:0] count_a, count_b;
`endif

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  rr_decode_arbiter #(.MAX_HOLD(4), .CNT_W(16)) dut_a (
    .clk(clk), .rst(rst), .req(req_a),
    .gnt(gnt_a), .gnt_idx(idx_a), .gnt_valid(valid_a)
`ifdef ARB_GRANT_COUNT_EN
    , .grant_count(count_a)
`endif
  );

  rr_decode_arbiter #(.MAX_HOLD(0), .CNT_W(16)) dut_b (
    .clk(clk), .rst(rst), .req(req_b),
    .gnt(gnt_b), .gnt_idx(idx_b), .gnt_valid(valid_b)
`ifdef ARB_GRANT_COUNT_EN
    , .grant_count(count_b)
`endif
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end else begin
      $display("ok   %s: %0h", tag, got);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_a(input string tag, input logic [7:0] g, input logic v);
    check({tag, ".gnt"}, 32'(gnt_a), 32'(g));
    check({tag, ".valid"}, 32'(valid_a), 32'(v));
  endtask

  initial begin
    logic [2:0] exp_idx;
    rst   = 1'b0;
    req_a = 8'h00;
    req_b = 8'h00;
    #1 rst = 1'b1;
    tick();
    tick();
    expect_a("reset", 8'h00, 1'b0);
    check("reset.idx", 32'(idx_a), 32'd0);
`ifdef ARB_GRANT_COUNT_EN
    check("reset.count", 32'(count_a), 32'd0);
`endif
    rst = 1'b0;

    // Idle with no requests
    for (int k = 0; k < 5; k++) begin
      tick();
      expect_a("idle", 8'h00, 1'b0);
      check("idle.idx", 32'(idx_a), 32'd0);
    end

    // Single requester 2 for two cycles, then release
    req_a = 8'h04;
    tick();
    expect_a("single.c1", 8'h04, 1'b1);
    check("single.c1.idx", 32'(idx_a), 32'd2);
    tick();
    expect_a("single.c2", 8'h04, 1'b1);
    req_a = 8'h00;
    tick();
    expect_a("single.rel", 8'h00, 1'b0);
    check("single.rel.idx_hold", 32'(idx_a), 32'd2);

    // ptr is now 3: requester 3 beats requester 0; drop on the grant cycle
    req_a = 8'h09;
    tick();
    expect_a("ptr3", 8'h08, 1'b1);
    check("ptr3.idx", 32'(idx_a), 32'd3);
    req_a = 8'h00;
    tick();
    expect_a("ptr3.rel", 8'h00, 1'b0);

    // All requesting from ptr=4: 4-cycle grants with one bubble each, 4..7,0..4
    req_a = 8'hFF;
    for (int k = 0; k < 45; k++) begin
      tick();
      exp_idx = 3'(4 + k / 5);
      if ((k % 5) < 4) begin
        expect_a($sformatf("all.k%0d", k), 8'd1 << exp_idx, 1'b1);
        check($sformatf("all.k%0d.idx", k), 32'(idx_a), 32'(exp_idx));
      end else begin
        expect_a($sformatf("all.k%0d", k), 8'h00, 1'b0);
      end
    end
    req_a = 8'h00;

    // ptr=5 here; grant 6 to move ptr to 7, then check wrap 7 -> 0
    req_a = 8'h40;
    tick();
    expect_a("to6", 8'h40, 1'b1);
    req_a = 8'h00;
    tick();
    expect_a("to6.rel", 8'h00, 1'b0);
    req_a = 8'h81;
    tick();
    expect_a("wrap.first", 8'h80, 1'b1);
    check("wrap.first.idx", 32'(idx_a), 32'd7);
    req_a = 8'h01;
    tick();
    expect_a("wrap.bubble", 8'h00, 1'b0);
    tick();
    expect_a("wrap.second", 8'h01, 1'b1);
    check("wrap.second.idx", 32'(idx_a), 32'd0);
    req_a = 8'h00;
    tick();
    expect_a("wrap.rel", 8'h00, 1'b0);

    // Lone requester 1 re-wins after its timeout bubble
    req_a = 8'h02;
    for (int k = 0; k < 6; k++) begin
      tick();
      if (k == 4) expect_a($sformatf("lone.k%0d", k), 8'h00, 1'b0);
      else        expect_a($sformatf("lone.k%0d", k), 8'h02, 1'b1);
    end
    req_a = 8'h00;
    tick();
    expect_a("lone.rel", 8'h00, 1'b0);

    // Reset asserted mid-grant clears outputs before the next edge
    req_a = 8'h20;
    tick();
    expect_a("mid.grant", 8'h20, 1'b1);
    check("mid.grant.idx", 32'(idx_a), 32'd5);
    #2 rst = 1'b1;
    #1;
    expect_a("mid.async", 8'h00, 1'b0);
    check("mid.async.idx", 32'(idx_a), 32'd0);
`ifdef ARB_GRANT_COUNT_EN
    check("mid.async.count", 32'(count_a), 32'd0);
`endif
    req_a = 8'h21;
    tick();
    rst = 1'b0;
    tick();
    expect_a("post.rst", 8'h01, 1'b1);
    check("post.rst.idx", 32'(idx_a), 32'd0);
`ifdef ARB_GRANT_COUNT_EN
    check("post.rst.count", 32'(count_a), 32'd1);
`endif
    req_a = 8'h00;
    tick();
    expect_a("post.rst.rel", 8'h00, 1'b0);

    // MAX_HOLD=0: no timeout, grant held for the whole request
    req_b = 8'h10;
    for (int k = 0; k < 20; k++) begin
      tick();
      check($sformatf("nohold.k%0d.gnt", k), 32'(gnt_b), 32'h10);
      check($sformatf("nohold.k%0d.valid", k), 32'(valid_b), 32'd1);
    end
    check("nohold.idx", 32'(idx_b), 32'd4);
    req_b = 8'h00;
    tick();
    check("nohold.rel.gnt", 32'(gnt_b), 32'h00);
    check("nohold.rel.valid", 32'(valid_b), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/rr_decode_arbiter.md
Name: rr_decode_arbiter

Overview:
- Round-robin arbiter sharing one 8-way decoded resource (register-file write port / 3-to-8 select line) among 8 requesters.
- Selects a winner, holds the grant while the winner keeps requesting, and enforces a maximum hold time.
- Drives the 3-bit index and the equivalent one-hot select, so downstream logic needs no separate decoder.

Parameters:
- MAX_HOLD, 4, maximum consecutive grant cycles per winner; 0 = unlimited.
- CNT_W, 16, width of the optional grant counter.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- req  input  8  per-requester request, level-sensitive; bit i = requester i.
- gnt  output  8  one-hot grant; all zero when idle.
- gnt_idx  output  3  binary index of current grantee; gnt == (1 << gnt_idx) whenever gnt_valid=1.
- gnt_valid  output  1  a grant is active this cycle.
- grant_count  output  CNT_W  number of grants issued; present only with ARB_GRANT_COUNT_EN.

Behaviour:
- Reset, asynchronous: state=IDLE, ptr=0, hold_cnt=0, gnt=8'b0, gnt_idx=3'b0, gnt_valid=0, grant_count=0.
- All outputs are registered. No combinational path from req to the outputs.
- FSM states: IDLE and GRANT.
- IDLE:
  - If req != 0, choose the first set bit scanning from ptr upward, modulo 8.
  - Next edge: state=GRANT, gnt_idx=winner, gnt=one-hot(winner), gnt_valid=1, hold_cnt=1.
  - Latency is one cycle, from req sampled high to gnt high.
  - If req == 0, stay in IDLE with outputs at zero.
- GRANT, release: if req[gnt_idx]=0, next edge goes to IDLE, gnt=0, gnt_valid=0, ptr=gnt_idx+1 (3-bit wrap, 7 -> 0).
- GRANT, timeout: if MAX_HOLD != 0 and hold_cnt == MAX_HOLD while req[gnt_idx]=1, the grant is revoked the same way (IDLE, ptr=gnt_idx+1).
- GRANT, continue: otherwise stay in GRANT and increment hold_cnt. hold_cnt saturates at MAX_HOLD; it is don't-care when MAX_HOLD=0.
- Every grant is followed by exactly one idle bubble cycle (gnt=0) before the next grant. This applies even if the same requester re-wins.
- Requests from other requesters during GRANT never preempt the current grant; only release or timeout ends it.
- Simultaneous requests: the requester nearest ptr wins, in upward circular order.
- Lone requester: it re-wins after every timeout bubble, at ptr-wrapped priority.
- Requester that drops req in the same cycle it is granted: the grant lasts one cycle, then release.
- gnt_idx holds its last value while idle; consumers qualify it with gnt_valid.
- Reset asserted mid-grant: outputs clear immediately (asynchronously). The first arbitration after reset release starts from ptr=0.
- Invariant: popcount(gnt) <= 1 at all times.

Optional Feature:
- Macro: ARB_GRANT_COUNT_EN.
- Defined:
  - Port grant_count exists.
  - It increments on every IDLE->GRANT transition.
  - It saturates at all-ones (no wrap).
  - It resets to 0.
- Undefined: the port and its counter are absent. All other behaviour is identical.

Test Plan:
- Reset, then req=8'h00 for 5 cycles -> gnt=8'h00, gnt_valid=0, gnt_idx=0 throughout.
- req=8'h04 held for 2 cycles then dropped, MAX_HOLD=4:
  - 1 cycle after req -> gnt=8'h04, gnt_idx=2.
  - Grant held 2 cycles, then gnt=8'h00.
  - ptr=3.
- req=8'hFF held constantly, MAX_HOLD=4:
  - Grants cycle idx 0,1,2,...,7,0.
  - Each grant lasts 4 cycles, followed by a 1-cycle gap.
  - Pattern period is 40 cycles.
- ptr=7 (after a grant to 6), then req=8'h81 -> idx 7 wins first; after its release, idx 0 wins (wrap-around).
- req=8'h10 under MAX_HOLD=0, held 20 cycles -> gnt=8'h10 for all 20 grant cycles, with no timeout bubble.
- Assert rst mid-grant (gnt=8'h20):
  - Outputs are 0 before the next clock edge.
  - After release with req=8'h21, idx 0 wins.
  - With ARB_GRANT_COUNT_EN, grant_count is 0 after reset and 1 after this grant.
